// File: rtl/clock_divider_bank_pkg.sv
// Shared constants, configuration record and helpers for the clock divider bank.
// Imported by the interface, the per-channel divider and the bank top.
package clock_divider_pkg;

    localparam int unsigned DEF_WIDTH       = 32'd28;
    localparam int unsigned DEFAULT_DIVISOR = 32'd50_000;
    localparam int unsigned MIN_DIVISOR     = 32'd2;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] divisor;
        logic [DEF_WIDTH-1:0] high;
    } div_cfg_t;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Configuration port of the clock divider bank: valid/ready write of one
// channel's divisor and high-time.
interface clock_divider_bank_if #(
    parameter int unsigned CHANNELS = 32'd4,
    parameter int unsigned WIDTH    = clock_divider_pkg::DEF_WIDTH
);
    localparam int unsigned CH_W = clock_divider_pkg::ch_width(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_channel;
    logic [WIDTH-1:0] cfg_divisor;
    logic [WIDTH-1:0] cfg_high;

    modport master (
        output cfg_valid, cfg_channel, cfg_divisor, cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_channel, cfg_divisor, cfg_high,
        output cfg_ready
    );

endinterface

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: period counter, active/shadow configuration and the
// boundary apply that keeps clock_out glitch-free across reconfiguration.
module clock_divider_channel #(
    parameter int unsigned WIDTH           = clock_divider_pkg::DEF_WIDTH,
    parameter int unsigned DEFAULT_DIVISOR = clock_divider_pkg::DEFAULT_DIVISOR,
    parameter int unsigned DEFAULT_HIGH    = DEFAULT_DIVISOR / 32'd2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_divisor,
    input  logic [WIDTH-1:0] wr_high,
    output logic             clock_out,
    output logic             tick,
    output logic             pending
);
    import clock_divider_pkg::*;

    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIVISOR);
    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(MIN_DIVISOR);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] div_active_r;
    logic [WIDTH-1:0] high_active_r;
    logic [WIDTH-1:0] div_shadow_r;
    logic [WIDTH-1:0] high_shadow_r;
    logic             pending_r;
    logic             clock_out_r;
    logic             tick_r;
    logic             last_s;
    logic             apply_s;
    logic [WIDTH-1:0] div_coerced_s;

    // End-of-period detect, apply qualification and divisor coercion
    always_comb begin
        last_s  = (cnt_r == div_active_r - ONE);
        apply_s = pending_r && (!enable || last_s);
        if (wr_divisor < MIN_DIV) begin
            div_coerced_s = MIN_DIV;
        end else begin
            div_coerced_s = wr_divisor;
        end
    end

    // Period counter and registered duty/tick outputs
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt_r       <= '0;
            clock_out_r <= 1'b0;
            tick_r      <= 1'b0;
        end else if (!enable) begin
            cnt_r       <= '0;
            clock_out_r <= 1'b0;
            tick_r      <= 1'b0;
        end else begin
            cnt_r       <= last_s ? '0 : cnt_r + ONE;
            clock_out_r <= (cnt_r < high_active_r);
            tick_r      <= last_s;
        end
    end

    // Shadow load on accepted write; copy to active only at a period boundary
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            div_active_r  <= DEF_DIV;
            high_active_r <= DEF_HIGH;
            div_shadow_r  <= DEF_DIV;
            high_shadow_r <= DEF_HIGH;
            pending_r     <= 1'b0;
        end else if (apply_s) begin
            div_active_r  <= div_shadow_r;
            high_active_r <= high_shadow_r;
            pending_r     <= 1'b0;
        end else if (wr_en) begin
            div_shadow_r  <= div_coerced_s;
            high_shadow_r <= wr_high;
            pending_r     <= 1'b1;
        end else begin
            pending_r     <= pending_r;
        end
    end

    assign clock_out = clock_out_r;
    assign tick      = tick_r;
    assign pending   = pending_r;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one configuration
// port; a write is held off while the target channel still has an update pending.
module clock_divider_bank #(
    parameter int unsigned CHANNELS        = 32'd4,
    parameter int unsigned WIDTH           = clock_divider_pkg::DEF_WIDTH,
    parameter int unsigned DEFAULT_DIVISOR = clock_divider_pkg::DEFAULT_DIVISOR,
    parameter int unsigned DEFAULT_HIGH    = DEFAULT_DIVISOR / 32'd2
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    clock_divider_bank_if.slave  cfg,
    output logic [CHANNELS-1:0]  clock_out,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  pending
);
    import clock_divider_pkg::*;

    localparam int unsigned CH_W = ch_width(CHANNELS);

    logic [CHANNELS-1:0] sel_s;
    logic [CHANNELS-1:0] wr_s;
    logic [CHANNELS-1:0] pending_s;
    logic [CHANNELS-1:0] clock_out_s;
    logic [CHANNELS-1:0] tick_s;

    // An out-of-range channel selects nothing, so it reads ready and is dropped
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign sel_s[i] = (cfg.cfg_channel == CH_W'(i));
        assign wr_s[i]  = cfg.cfg_valid & sel_s[i] & ~pending_s[i];

        clock_divider_channel #(
            .WIDTH           (WIDTH),
            .DEFAULT_DIVISOR (DEFAULT_DIVISOR),
            .DEFAULT_HIGH    (DEFAULT_HIGH)
        ) u_channel (
            .clock_in   (clock_in),
            .reset      (reset),
            .enable     (enable[i]),
            .wr_en      (wr_s[i]),
            .wr_divisor (cfg.cfg_divisor),
            .wr_high    (cfg.cfg_high),
            .clock_out  (clock_out_s[i]),
            .tick       (tick_s[i]),
            .pending    (pending_s[i])
        );
    end

    assign cfg.cfg_ready = ~|(sel_s & pending_s);
    assign clock_out     = clock_out_s;
    assign tick          = tick_s;
    assign pending       = pending_s;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: two-channel divider with small
// defaults, plus a three-channel instance for the unused channel code.
module tb_clock_divider_bank;

    logic       clock_in = 1'b0;
    logic       reset;
    logic [1:0] enable;
    logic [1:0] clock_out;
    logic [1:0] tick;
    logic [1:0] pending;
    logic [2:0] enable3;
    logic [2:0] clock_out3;
    logic [2:0] tick3;
    logic [2:0] pending3;

    int passed = 0;
    int total  = 0;
    logic [63:0] cap_co0, cap_co1, cap_tk0, cap_tk1, cap_pd0;

    clock_divider_bank_if #(.CHANNELS(2), .WIDTH(8)) cfg_if ();
    clock_divider_bank_if #(.CHANNELS(3), .WIDTH(8)) cfg3_if ();

    clock_divider_bank #(.CHANNELS(2), .WIDTH(8), .DEFAULT_DIVISOR(10), .DEFAULT_HIGH(5)) u_dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .cfg       (cfg_if),
        .clock_out (clock_out),
        .tick      (tick),
        .pending   (pending)
    );

    clock_divider_bank #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIVISOR(4), .DEFAULT_HIGH(2)) u_dut3 (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable3),
        .cfg       (cfg3_if),
        .clock_out (clock_out3),
        .tick      (tick3),
        .pending   (pending3)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            @(negedge clock_in);
        end
    endtask

    // bit i of each capture = value after the (i+1)th rising edge
    task automatic capture(input int n);
        cap_co0 = '0; cap_co1 = '0; cap_tk0 = '0; cap_tk1 = '0; cap_pd0 = '0;
        for (int i = 0; i < n; i++) begin
            step(1);
            cap_co0[i] = clock_out[0];
            cap_co1[i] = clock_out[1];
            cap_tk0[i] = tick[0];
            cap_tk1[i] = tick[1];
            cap_pd0[i] = pending[0];
        end
    endtask

    task automatic drive_cfg(input logic valid, input logic ch, input logic [7:0] div, input logic [7:0] high);
        cfg_if.cfg_valid   = valid;
        cfg_if.cfg_channel = ch;
        cfg_if.cfg_divisor = div;
        cfg_if.cfg_high    = high;
    endtask

    // Disable ch0, write it, let the disabled apply happen, re-enable
    task automatic load_ch0(input logic [7:0] div, input logic [7:0] high);
        enable[0] = 1'b0;
        step(1);
        drive_cfg(1'b1, 1'b0, div, high);
        step(1);
        drive_cfg(1'b0, 1'b0, 8'd0, 8'd0);
        step(1);
        enable[0] = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 2'b00;
        enable3 = 3'b111;
        drive_cfg(1'b0, 1'b0, 8'd0, 8'd0);
        cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_channel = 2'd0;
        cfg3_if.cfg_divisor = 8'd0; cfg3_if.cfg_high = 8'd0;
        step(2);
        total++; if (clock_out !== 2'b00) $display("FAIL reset_clock_out: got %b expected 00", clock_out); else passed++;
        total++; if (tick !== 2'b00) $display("FAIL reset_tick: got %b expected 00", tick); else passed++;
        total++; if (pending !== 2'b00) $display("FAIL reset_pending: got %b expected 00", pending); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready_ch0: got %b expected 1", cfg_if.cfg_ready); else passed++;
        cfg_if.cfg_channel = 1'b1;
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready_ch1: got %b expected 1", cfg_if.cfg_ready); else passed++;
        cfg_if.cfg_channel = 1'b0;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_defaults();
        enable = 2'b11;
        capture(20);
        total++; if (cap_co0 !== 64'h7C1F) $display("FAIL default_co0: got %h expected 7c1f", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'h80200) $display("FAIL default_tk0: got %h expected 80200", cap_tk0); else passed++;
        total++; if (cap_co1 !== 64'h7C1F) $display("FAIL default_co1: got %h expected 7c1f", cap_co1); else passed++;
        total++; if (cap_tk1 !== 64'h80200) $display("FAIL default_tk1: got %h expected 80200", cap_tk1); else passed++;
        total++; if (pending !== 2'b00) $display("FAIL default_pending: got %b expected 00", pending); else passed++;
    endtask

    task automatic test_running_reconfig();
        step(3);
        drive_cfg(1'b1, 1'b0, 8'd4, 8'd1);
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reconf_ready_before: got %b expected 1", cfg_if.cfg_ready); else passed++;
        step(1);
        drive_cfg(1'b0, 1'b0, 8'd0, 8'd0);
        #1;
        total++; if (pending !== 2'b01) $display("FAIL reconf_pending: got %b expected 01", pending); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL reconf_ready_held: got %b expected 0", cfg_if.cfg_ready); else passed++;
        capture(14);
        total++; if (cap_co0 !== 64'h441) $display("FAIL reconf_co0: got %h expected 441", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'h2220) $display("FAIL reconf_tk0: got %h expected 2220", cap_tk0); else passed++;
        total++; if (cap_pd0 !== 64'h1F) $display("FAIL reconf_pd0: got %h expected 1f", cap_pd0); else passed++;
    endtask

    task automatic test_back_to_back();
        int waits;
        drive_cfg(1'b1, 1'b0, 8'd6, 8'd3);
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b expected 1", cfg_if.cfg_ready); else passed++;
        step(1);
        drive_cfg(1'b1, 1'b0, 8'd8, 8'd2);
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL b2b_second_held: got %b expected 0", cfg_if.cfg_ready); else passed++;
        drive_cfg(1'b1, 1'b1, 8'd5, 8'd2);
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL b2b_ch1_ready: got %b expected 1", cfg_if.cfg_ready); else passed++;
        step(1);
        total++; if (pending !== 2'b11) $display("FAIL b2b_both_pending: got %b expected 11", pending); else passed++;
        drive_cfg(1'b1, 1'b0, 8'd8, 8'd2);
        #1;
        waits = 0;
        while (cfg_if.cfg_ready !== 1'b1 && waits < 20) begin
            step(1);
            waits++;
        end
        total++; if (waits !== 2) $display("FAIL b2b_hold_cycles: got %0d expected 2", waits); else passed++;
        step(1);
        drive_cfg(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (pending !== 2'b11) $display("FAIL b2b_second_accepted: got %b expected 11", pending); else passed++;
        capture(17);
        total++; if (cap_co0 !== 64'h6063) $display("FAIL b2b_co0: got %h expected 6063", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'h1010) $display("FAIL b2b_tk0: got %h expected 1010", cap_tk0); else passed++;
        total++; if (cap_co1 !== 64'h3183) $display("FAIL b2b_co1: got %h expected 3183", cap_co1); else passed++;
        total++; if (cap_tk1 !== 64'h10840) $display("FAIL b2b_tk1: got %h expected 10840", cap_tk1); else passed++;
        total++; if (pending !== 2'b00) $display("FAIL b2b_pending_cleared: got %b expected 00", pending); else passed++;
    endtask

    task automatic test_disable_enable();
        enable = 2'b01;
        step(1);
        total++; if (clock_out[1] !== 1'b0) $display("FAIL dis_clock_out1: got %b expected 0", clock_out[1]); else passed++;
        total++; if (tick[1] !== 1'b0) $display("FAIL dis_tick1: got %b expected 0", tick[1]); else passed++;
        drive_cfg(1'b1, 1'b1, 8'd3, 8'd1);
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL dis_ready: got %b expected 1", cfg_if.cfg_ready); else passed++;
        step(1);
        drive_cfg(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (pending[1] !== 1'b1) $display("FAIL dis_pending_set: got %b expected 1", pending[1]); else passed++;
        step(1);
        total++; if (pending[1] !== 1'b0) $display("FAIL dis_applied: got %b expected 0", pending[1]); else passed++;
        enable = 2'b11;
        capture(9);
        total++; if (cap_co1 !== 64'h49) $display("FAIL reen_co1: got %h expected 49", cap_co1); else passed++;
        total++; if (cap_tk1 !== 64'h124) $display("FAIL reen_tk1: got %h expected 124", cap_tk1); else passed++;
    endtask

    task automatic test_boundaries();
        int ones;
        int tks;
        load_ch0(8'd0, 8'd1);
        capture(8);
        total++; if (cap_co0 !== 64'h55) $display("FAIL div0_co0: got %h expected 55", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'hAA) $display("FAIL div0_tk0: got %h expected aa", cap_tk0); else passed++;
        load_ch0(8'd4, 8'd0);
        capture(8);
        total++; if (cap_co0 !== 64'h0) $display("FAIL high0_co0: got %h expected 0", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'h88) $display("FAIL high0_tk0: got %h expected 88", cap_tk0); else passed++;
        load_ch0(8'd10, 8'd20);
        capture(12);
        total++; if (cap_co0 !== 64'hFFF) $display("FAIL highbig_co0: got %h expected fff", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'h200) $display("FAIL highbig_tk0: got %h expected 200", cap_tk0); else passed++;
        cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_channel = 2'd3;
        cfg3_if.cfg_divisor = 8'd2; cfg3_if.cfg_high = 8'd1;
        #1;
        total++; if (cfg3_if.cfg_ready !== 1'b1) $display("FAIL badch_ready: got %b expected 1", cfg3_if.cfg_ready); else passed++;
        step(1);
        cfg3_if.cfg_valid = 1'b0;
        total++; if (pending3 !== 3'b000) $display("FAIL badch_pending: got %b expected 000", pending3); else passed++;
        ones = 0;
        tks  = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            ones += int'(clock_out3[2]);
            tks  += int'(tick3[2]);
        end
        total++; if (ones !== 4) $display("FAIL badch_ch2_high: got %0d expected 4", ones); else passed++;
        total++; if (tks !== 2) $display("FAIL badch_ch2_ticks: got %0d expected 2", tks); else passed++;
    endtask

    task automatic test_async_reset();
        drive_cfg(1'b1, 1'b0, 8'd4, 8'd1);
        step(1);
        drive_cfg(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (pending !== 2'b01) $display("FAIL arst_pending_pre: got %b expected 01", pending); else passed++;
        #1;
        reset = 1'b1;
        #1;
        total++; if (clock_out !== 2'b00) $display("FAIL arst_clock_out: got %b expected 00", clock_out); else passed++;
        total++; if (tick !== 2'b00) $display("FAIL arst_tick: got %b expected 00", tick); else passed++;
        total++; if (pending !== 2'b00) $display("FAIL arst_pending: got %b expected 00", pending); else passed++;
        step(1);
        reset = 1'b0;
        capture(20);
        total++; if (cap_co0 !== 64'h7C1F) $display("FAIL arst_co0: got %h expected 7c1f", cap_co0); else passed++;
        total++; if (cap_tk0 !== 64'h80200) $display("FAIL arst_tk0: got %h expected 80200", cap_tk0); else passed++;
        total++; if (cap_co1 !== 64'h7C1F) $display("FAIL arst_co1: got %h expected 7c1f", cap_co1); else passed++;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_running_reconfig();
        test_back_to_back();
        test_disable_enable();
        test_boundaries();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
